// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte offset of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush; flush beats push.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: fetch PC, in-order imem requests, prefetch FIFO, redirect.
// Optional IFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             running;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_nxt;

  logic [31:0]      shadow_q [DEPTH];
  logic [PTR_W-1:0] sh_wr;
  logic [PTR_W-1:0] sh_rd;
  logic [31:0]      rsp_pc;

  logic             req_fire;
  logic             rsp_keep;
  logic             retire;
  logic             redirect;

  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;

  // Issue only while in-flight plus buffered words leave room in the FIFO.
  assign imem_req_valid = running & ~fifo_full &
                          ((SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_keep = imem_rsp_valid & (discard == '0);
  assign retire   = instr_valid & instr_ready;
  assign redirect = retire & PCSrc;
  assign rsp_pc   = shadow_q[sh_rd];

`ifdef IFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = fifo_empty & rsp_keep;
  assign fifo_push  = rsp_keep & ~redirect & ~(bypass_hit & instr_ready);
`else
  assign fifo_push  = rsp_keep & ~redirect;
`endif

  assign fifo_pop   = retire & ~fifo_empty;
  assign fifo_wdata = '{pc: rsp_pc, instr: imem_rsp_data};

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Next fetch PC and counters; discard covers every request still in flight after a redirect.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    discard_nxt     = discard;

    if (imem_rsp_valid && (discard != '0)) discard_nxt = discard - CNT_W'(1);
    if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;

    if (redirect) begin
      fetch_pc_nxt = word_align(PCTarget);
      discard_nxt  = outstanding_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      fetch_pc    <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      running     <= 1'b1;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // In-order shadow of issued addresses; every response, kept or dropped, consumes one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_wr <= '0;
      sh_rd <= '0;
    end else begin
      if (req_fire)       sh_wr <= sh_wr + PTR_W'(1);
      if (imem_rsp_valid) sh_rd <= sh_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) shadow_q[sh_wr] <= fetch_pc;
  end

  // Head presentation; NOP and PC 0 when nothing is valid.
  always_comb begin
    instr_valid = 1'b0;
    Instr       = NOP_INSTR;
    PC          = '0;
    if (!fifo_empty) begin
      instr_valid = 1'b1;
      Instr       = fifo_head.instr;
      PC          = fifo_head.pc;
    end
`ifdef IFETCH_BYPASS_EN
    else if (bypass_hit) begin
      instr_valid = 1'b1;
      Instr       = imem_rsp_data;
      PC          = rsp_pc;
    end
`endif
  end

  assign PCPlus4  = PC + 32'd4;
  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a 1-cycle-latency in-order instruction memory model.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;

  int total = 0;
  int bad   = 0;
  int issued;
  int max_inflight;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .Instr          (Instr),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .op             (op),
    .funct3         (funct3),
    .funct7b5       (funct7b5)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return 32'hA000_0000 | a;
    endcase
  endfunction

  // Memory: answers each accepted request in the following cycle, in order.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
      issued         <= 0;
      max_inflight   <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        issued <= issued + 1;
      end
      if (mq.size() > max_inflight) max_inflight <= mq.size();
      if (mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    PCSrc          = 1'b0;
    PCTarget       = 32'h0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; PCSrc = 1'b0; PCTarget = 32'h0;
    repeat (2) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h want 00000000", imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %0b want 0", instr_valid); end
    total++; if (Instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr: got %h want 00000013", Instr); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 00000000", PC); end
    total++; if (PCPlus4 !== 32'h4) begin bad++; $display("FAIL rst_pcplus4: got %h want 00000004", PCPlus4); end
    total++; if (op !== 7'h13) begin bad++; $display("FAIL rst_op: got %h want 13", op); end
    total++; if (funct3 !== 3'h0) begin bad++; $display("FAIL rst_funct3: got %h want 0", funct3); end
    total++; if (funct7b5 !== 1'b0) begin bad++; $display("FAIL rst_funct7b5: got %0b want 0", funct7b5); end
    reset_n = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rel_req_valid: got %0b want 1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rel_req_addr: got %h want 00000000", imem_req_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL basic_c1_req: got v=%0b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_c2_ivalid: got %0b want 0", instr_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL basic_c2_req: got v=%0b a=%h want v=1 a=00000004", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_c3_ivalid: got %0b want 1", instr_valid); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL basic_c3_pc: got %h want 00000000", PC); end
    total++; if (Instr !== 32'h0050_0093) begin bad++; $display("FAIL basic_c3_instr: got %h want 00500093", Instr); end
    total++; if (op !== 7'h13 || funct3 !== 3'h0) begin bad++; $display("FAIL basic_c3_decode: got op=%h f3=%h want op=13 f3=0", op, funct3); end
    total++; if (PCPlus4 !== 32'h4) begin bad++; $display("FAIL basic_c3_pcplus4: got %h want 00000004", PCPlus4); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_c3_req_full: got %0b want 0", imem_req_valid); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h4) begin bad++; $display("FAIL basic_c4_pc: got v=%0b pc=%h want v=1 pc=00000004", instr_valid, PC); end
    total++; if (Instr !== 32'h0010_0113) begin bad++; $display("FAIL basic_c4_instr: got %h want 00100113", Instr); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL basic_c4_req: got v=%0b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    repeat (3) tick();
    imem_req_ready = 1'b0;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_c4_req: got v=%0b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL stall_c4_pc: got %h want 00000004", PC); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_c5_req: got v=%0b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_c5_ivalid: got %0b want 0", instr_valid); end
    tick();
    total++; if (imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_c6_addr: got %h want 00000008", imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    total++; if (imem_req_addr !== 32'hC) begin bad++; $display("FAIL stall_c7_addr: got %h want 0000000c", imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h8 || Instr !== 32'hA000_0008) begin bad++; $display("FAIL stall_c8_head: got v=%0b pc=%h i=%h want v=1 pc=00000008 i=a0000008", instr_valid, PC, Instr); end
    total++; if (max_inflight > DEPTH) begin bad++; $display("FAIL stall_inflight: got %0d want <=%0d", max_inflight, DEPTH); end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (3) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_c3_req: got %0b want 0", imem_req_valid); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0) begin bad++; $display("FAIL bp_c4_head: got v=%0b pc=%h want v=1 pc=00000000", instr_valid, PC); end
    repeat (4) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_c8_req: got %0b want 0", imem_req_valid); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL bp_c8_pc: got %h want 00000000", PC); end
    total++; if (issued !== 2) begin bad++; $display("FAIL bp_issued: got %0d want 2", issued); end
    instr_ready = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL bp_c9_req: got v=%0b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL bp_c9_pc: got %h want 00000004", PC); end
    total++; if (max_inflight > DEPTH) begin bad++; $display("FAIL bp_inflight: got %0d want <=%0d", max_inflight, DEPTH); end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h4) begin bad++; $display("FAIL redir_c5_head: got v=%0b pc=%h want v=1 pc=00000004", instr_valid, PC); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL redir_c5_req: got v=%0b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
    PCSrc = 1'b1; PCTarget = 32'h40;
    tick();
    PCSrc = 1'b0; instr_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin bad++; $display("FAIL redir_c6_req: got v=%0b a=%h want v=1 a=00000040", imem_req_valid, imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_c6_ivalid: got %0b want 0", instr_valid); end
    total++; if (issued !== 3) begin bad++; $display("FAIL redir_issued: got %0d want 3", issued); end
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_c7_drop: got %0b want 0", instr_valid); end
    total++; if (imem_req_addr !== 32'h44) begin bad++; $display("FAIL redir_c7_addr: got %h want 00000044", imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h40) begin bad++; $display("FAIL redir_c8_head: got v=%0b pc=%h want v=1 pc=00000040", instr_valid, PC); end
    total++; if (Instr !== 32'hA000_0040 || op !== 7'h40 || funct7b5 !== 1'b0) begin bad++; $display("FAIL redir_c8_instr: got i=%h op=%h f7=%0b want i=a0000040 op=40 f7=0", Instr, op, funct7b5); end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    repeat (3) tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0) begin bad++; $display("FAIL sc_c3_head: got v=%0b pc=%h want v=1 pc=00000000", instr_valid, PC); end
    PCSrc = 1'b1; PCTarget = 32'h43;
    tick();
    PCSrc = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin bad++; $display("FAIL sc_c4_req: got v=%0b a=%h want v=1 a=00000040", imem_req_valid, imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL sc_c4_drop: got %0b want 0", instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h44) begin bad++; $display("FAIL sc_c5: got v=%0b a=%h want v=0 a=00000044", instr_valid, imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h40 || PCPlus4 !== 32'h44) begin bad++; $display("FAIL sc_c6_head: got v=%0b pc=%h p4=%h want v=1 pc=00000040 p4=00000044", instr_valid, PC, PCPlus4); end
    reset_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_req: got v=%0b a=%h want v=0 a=00000000", imem_req_valid, imem_req_addr); end
    total++; if (instr_valid !== 1'b0 || Instr !== 32'h13 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin bad++; $display("FAIL mid_rst_out: got v=%0b i=%h pc=%h p4=%h want v=0 i=00000013 pc=0 p4=4", instr_valid, Instr, PC, PCPlus4); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL post_rst_c1: got v=%0b a=%h iv=%0b want v=1 a=0 iv=0", imem_req_valid, imem_req_addr, instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL post_rst_c2: got %0b want 0", instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0 || Instr !== 32'h0050_0093) begin bad++; $display("FAIL post_rst_c3: got v=%0b pc=%h i=%h want v=1 pc=0 i=00500093", instr_valid, PC, Instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) tick();
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF;
    tick();
    PCSrc = 1'b0;
    total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_c4_addr: got %h want fffffffc", imem_req_addr); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_c5_addr: got v=%0b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_c6_pc: got v=%0b pc=%h p4=%h want v=1 pc=fffffffc p4=00000000", instr_valid, PC, PCPlus4); end
    total++; if (op !== 7'h7C || funct3 !== 3'h7 || funct7b5 !== 1'b1) begin bad++; $display("FAIL wrap_c6_decode: got op=%h f3=%h f7=%0b want op=7c f3=7 f7=1", op, funct3, funct7b5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_backpressure();
    test_redirect();
    test_same_cycle_and_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
